// File: rtl/dsc_mul_seq.sv
// Deterministic stochastic (unary) multiplier sequencer: A stream at full rate,
// B stream advanced once per A period, product bits counted into z = a*b.
// Latency b*2^W+1 cycles accept->out_valid (en high); en low stalls RUN; no new operands until DONE handshake.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-low reset
//   en              run enable, low freezes the RUN state
//   in_valid/ready  operand handshake carrying a, b (unsigned, SNG_WIDTH bits)
//   out_valid/ready result handshake carrying z (unsigned, NUM_INPUTS*SNG_WIDTH bits)
//   busy            high while a multiplication is running or its result is pending
module dsc_mul_seq #(
    parameter int SNG_WIDTH  = 6,
    parameter int NUM_INPUTS = 2          // only 2 operands supported
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SNG_WIDTH-1:0]            a,
    input  logic [SNG_WIDTH-1:0]            b,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_INPUTS*SNG_WIDTH-1:0] z,
    output logic                            busy
);

    localparam int ZW = NUM_INPUTS * SNG_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SNG_WIDTH-1:0] a_r, b_r;
    logic [SNG_WIDTH-1:0] ca, cb;
    logic [ZW-1:0]        z_q;

    logic accept;      // operand handshake this cycle
    logic b_spent;     // B stream has emitted all of its ones
    logic step;        // one stream bit is generated and counted this cycle
    logic bit_a;
    logic bit_b;
    logic ca_wrap;     // last bit of the current A period

    assign accept  = (state_q == S_IDLE) && in_valid;
    assign b_spent = (cb == b_r);
    assign step    = (state_q == S_RUN) && en && !b_spent;
    assign bit_a   = (ca < a_r);
    assign bit_b   = (cb < b_r);
    assign ca_wrap = (ca == {SNG_WIDTH{1'b1}});

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid)             state_d = S_RUN;
            S_RUN:  if (en && b_spent)        state_d = S_DONE;
            S_DONE: if (out_ready)            state_d = S_IDLE;
            default:                          state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_RUN:  busy     = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Stream counters and product accumulator. cb stops at b_r (early
    // shutoff), so it can never wrap and z ends at exactly a_r*b_r.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_r <= '0;
            b_r <= '0;
            ca  <= '0;
            cb  <= '0;
            z_q <= '0;
        end else if (accept) begin
            a_r <= a;
            b_r <= b;
            ca  <= '0;
            cb  <= '0;
            z_q <= '0;
        end else if (step) begin
            z_q <= z_q + ZW'(bit_a & bit_b);
            ca  <= ca + 1'b1;
            if (ca_wrap) begin
                cb <= cb + 1'b1;
            end
        end
    end

    assign z = z_q;

endmodule

// File: tb/tb_dsc_mul_seq.sv
module tb_dsc_mul_seq;

    localparam int W  = 6;
    localparam int ZW = 2 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [ZW-1:0] z;
    logic          busy;

    dsc_mul_seq #(.SNG_WIDTH(W), .NUM_INPUTS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint zv;
        int     lat;
    } exp_t;

    exp_t q[$];
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   n_done   = 0;
    int   exp_done = 0;
    int   cyc      = 0;
    int   acc_edge = 0;
    int   hs_edge  = 0;
    bit   prev_ov  = 1'b0;
    bit   post_hs  = 1'b0;
    bit   chk_b2b  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, compares against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (in_valid && in_ready) begin
                acc_edge = cyc + 1;
                if (chk_b2b) begin
                    check("b2b_accept_edge", acc_edge, hs_edge + 1);
                    chk_b2b = 1'b0;
                end
            end
            if (post_hs) begin
                check("idle_after_hs_in_ready", in_ready, 1);
                check("idle_after_hs_out_valid", out_valid, 0);
                post_hs = 1'b0;
            end
            if (busy) check("in_ready_low_while_busy", in_ready, 0);
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_out_valid", out_valid, 0);
                end else begin
                    if (!prev_ov) check("latency", cyc - acc_edge, q[0].lat);
                    check("z", z, q[0].zv);
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_done++;
                        hs_edge = cyc + 1;
                        post_hs = 1'b1;
                    end
                end
            end
            prev_ov = out_valid;
        end else begin
            prev_ov = 1'b0;
            post_hs = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_result(input longint zv, input int lat);
        exp_t e;
        e.zv  = zv;
        e.lat = lat;
        q.push_back(e);
        exp_done++;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100 && !in_ready; i++) tick();
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
    endtask

    task automatic send(input int av, input int bv);
        wait_ready();
        in_valid = 1'b1;
        a = W'(av);
        b = W'(bv);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int n);
        for (int i = 0; i < 6000 && n_done < n; i++) tick();
        if (n_done < n) check("done_timeout", n_done, n);
    endtask

    task automatic wait_out_valid();
        for (int i = 0; i < 6000 && !out_valid; i++) tick();
        if (!out_valid) check("out_valid_timeout", out_valid, 1);
    endtask

    initial begin
        rst       = 1'b0;
        en        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_z", z, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b1;
        tick();

        // 1: basic product, 3*64+1 cycles
        expect_result(15, 193);
        send(5, 3);
        wait_done(exp_done);

        // 2: b=0 shuts off at once; a=0 still runs the full B length
        expect_result(0, 1);
        send(63, 0);
        wait_done(exp_done);
        expect_result(0, 257);
        send(0, 4);
        wait_done(exp_done);

        // 3: maximum operands, cb must stop at 63
        expect_result(3969, 4033);
        send(63, 63);
        wait_done(exp_done);

        // 4: enable stall mid-run, then consumer backpressure in DONE
        out_ready = 1'b0;
        expect_result(20, 149);
        send(10, 2);
        repeat (30) tick();
        en = 1'b0;
        repeat (20) tick();
        en = 1'b1;
        wait_out_valid();
        for (int i = 0; i < 10; i++) begin
            in_valid = (i >= 2 && i < 5);
            a = 1;
            b = 1;
            tick();
        end
        in_valid = 1'b0;
        check("done_hold_out_valid", out_valid, 1);
        check("done_hold_z", z, 20);
        out_ready = 1'b1;
        wait_done(exp_done);

        // 5: reset in the middle of a run
        send(7, 9);
        repeat (49) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midrun_rst_out_valid", out_valid, 0);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_z", z, 0);
        check("midrun_rst_in_ready", in_ready, 1);
        expect_result(1, 65);
        send(1, 1);
        wait_done(exp_done);

        // 6: back-to-back with in_valid held high
        expect_result(2, 65);
        expect_result(3, 65);
        wait_ready();
        in_valid = 1'b1;
        a = 2;
        b = 1;
        tick();
        a = 3;
        chk_b2b = 1'b1;
        wait_done(exp_done - 1);
        for (int i = 0; i < 5 && !busy; i++) tick();
        in_valid = 1'b0;
        check("b2b_second_accepted", busy, 1);
        wait_done(exp_done);
        check("b2b_checked", chk_b2b, 0);

        repeat (3) tick();
        check("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
